// File: rtl/uart_disp_pkg.sv
// Shared types and width helpers for the UART display scheduler.
//   state_e      scheduler FSM states
//   BYTE_W       width of a displayed byte
//   timer_width  bit width needed to count up to max(dwell, gap) - 1
package uart_disp_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Never returns 0 so the timer register always has at least one bit.
  function automatic int unsigned timer_width(input int unsigned dwell,
                                              input int unsigned gap);
    int unsigned m;
    m = (dwell > gap) ? dwell : gap;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// DEPTH x 8 byte FIFO with occupancy count.
//   clk        clock, posedge
//   rst        asynchronous active-low reset
//   push       write wr_data (accepted when not full, or when popping the same cycle)
//   pop        read/advance head (ignored when empty)
//   wr_data    byte to write
//   rd_data_c  head byte (combinational)
//   full_c     level == DEPTH (combinational)
//   empty_c    level == 0 (combinational)
//   level      entries buffered, 0..DEPTH
module byte_fifo
  import uart_disp_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [BYTE_W-1:0]       wr_data,
  output logic [BYTE_W-1:0]       rd_data_c,
  output logic                    full_c,
  output logic                    empty_c,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full_c    = (level == LW'(DEPTH));
  assign empty_c   = (level == '0);
  assign push_ok   = push & (~full_c | pop);
  assign pop_ok    = pop & ~empty_c;
  assign rd_data_c = mem[rd_ptr];

  // Storage needs no reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_disp_sched.sv
// Paces received UART bytes onto the seven-segment display: each byte is shown
// for DWELL_CYCLES, then the display is blanked for GAP_CYCLES; bursts wait in a FIFO.
//   clk         clock, posedge
//   rst         asynchronous active-low reset
//   rx_data     byte from uart_rx
//   rx_valid    one-cycle strobe qualifying rx_data
//   hold        freezes the dwell timer while a byte is shown
//   disp_data   byte to seven_seg
//   disp_blank  1 = display all segments off
//   fifo_level  entries currently buffered
//   overflow    sticky: a byte was dropped on a full FIFO
module uart_disp_sched
  import uart_disp_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned DWELL_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES   = 2_500_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BYTE_W-1:0]       rx_data,
  input  logic                    rx_valid,
  input  logic                    hold,
  output logic [BYTE_W-1:0]       disp_data,
  output logic                    disp_blank,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    overflow
);

  localparam int unsigned TW = timer_width(DWELL_CYCLES, GAP_CYCLES);

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [BYTE_W-1:0] data_d;
  logic              blank_d;
  logic              pop_c;
  logic [BYTE_W-1:0] head_c;
  logic              full_c;
  logic              empty_c;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_valid),
    .pop       (pop_c),
    .wr_data   (rx_data),
    .rd_data_c (head_c),
    .full_c    (full_c),
    .empty_c   (empty_c),
    .level     (fifo_level)
  );

  // State, timer and display registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      disp_data  <= '0;
      disp_blank <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      disp_data  <= data_d;
      disp_blank <= blank_d;
    end
  end

  // A drop is a push that the FIFO cannot take this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow <= 1'b0;
    else if (rx_valid && full_c && !pop_c) overflow <= 1'b1;
  end

  // Next-state, timer and display load; popping always loads the head byte.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    data_d  = disp_data;
    blank_d = disp_blank;
    pop_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!empty_c) begin
          pop_c   = 1'b1;
          data_d  = head_c;
          blank_d = 1'b0;
          timer_d = '0;
          state_d = SHOW;
        end
      end

      SHOW: begin
        if (!hold) begin
          if (timer_q == TW'(DWELL_CYCLES - 1)) begin
            timer_d = '0;
            if (GAP_CYCLES > 0) begin
              blank_d = 1'b1;
              state_d = GAP;
            end else if (!empty_c) begin
              pop_c  = 1'b1;
              data_d = head_c;
            end else begin
              state_d = IDLE;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end

      GAP: begin
        // hold is deliberately ignored while blanked.
        if (timer_q == TW'(GAP_CYCLES - 1)) begin
          timer_d = '0;
          blank_d = 1'b0;
          if (!empty_c) begin
            pop_c   = 1'b1;
            data_d  = head_c;
            state_d = SHOW;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

endmodule
